param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count: a power of two, >=4.
REQ-003 Parameter AF_THRESH, default DEPTH-2, SHALL set the almost_full threshold (1..DEPTH-1).
REQ-004 Parameter AE_THRESH, default 2, SHALL set the almost_empty threshold (1..DEPTH-1).
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous active-low reset.
REQ-007 w_en  input  1  SHALL be the write request.
REQ-008 r_en  input  1  SHALL be the read request.
REQ-009 din  input  WIDTH  SHALL carry the write data.
REQ-010 dataout  output  WIDTH  SHALL carry the read data.
REQ-011 full, empty  output  1 each  SHALL be the occupancy flags.
REQ-012 almost_full, almost_empty  output  1 each  SHALL be the threshold flags.
REQ-013 count  output  $clog2(DEPTH)+1  SHALL give the current occupancy, 0..DEPTH.
REQ-014 overflow, underflow  output  1 each  SHALL be the error pulses.

Function
REQ-015 A read SHALL be accepted iff r_en && !empty.
REQ-016 A write SHALL be accepted iff w_en && (!full || read accepted in the same cycle), so a simultaneous read and write at full both complete.
REQ-017 A simultaneous r_en and w_en at empty SHALL accept the write, reject the read and assert underflow.
REQ-018 Read and write pointers SHALL be $clog2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH, and address memory with their low bits.
REQ-019 count SHALL increment on a write-only accept, decrement on a read-only accept, and hold on both or neither.
REQ-020 Flags SHALL be registered and consistent with count in the same cycle.
- full = (count==DEPTH)
- empty = (count==0)
- almost_full = (count>=AF_THRESH)
- almost_empty = (count<=AE_THRESH)
REQ-021 overflow SHALL pulse high for exactly one cycle, the cycle after a rejected w_en; underflow SHALL do the same for a rejected r_en.
REQ-022 Rejected requests SHALL alter no pointer, count or memory entry.
REQ-023 Without FWFT, dataout SHALL load the head entry one cycle after an accepted read and otherwise hold its value.
REQ-024 Data order SHALL be strict FIFO across any number of pointer wrap-arounds.

Reset
REQ-025 When rst is low, the block SHALL asynchronously clear pointers, count, dataout, full, almost_full, overflow and underflow to 0, and set empty and almost_empty to 1.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored data; the first rising edge with rst high SHALL honour requests normally.

Configuration
REQ-028 Macro FIFO_FWFT_EN SHALL select first-word-fall-through mode when defined.
- Defined: dataout shows the head entry combinationally whenever !empty; an accepted read advances it to the next entry; read latency is 0.
- Undefined: registered read per REQ-023; read latency is 1.
- Flag, count and error behaviour SHALL be identical in both modes.

Structure
REQ-029 Package fifo_pkg SHALL hold the default WIDTH/DEPTH constants and a typedef for the error-status pair {overflow, underflow}.
REQ-030 Storage SHALL be a sub-module fifo_mem: one write port, one read port, DEPTH x WIDTH, no reset.
REQ-031 Pointer, count and flag logic SHALL reside in param_sync_fifo.

Verification
REQ-032 The bench SHALL cover:
- Reset, then 16 writes of 0x01..0x10 (DEPTH=16) -> full=1 and count=16 after the 16th write; almost_full=1 from count 14.
- At full, w_en only with din=0xAA -> write rejected, overflow pulses 1 cycle, count stays 16, no data corrupted.
- At full, r_en and w_en together with din=0x55 -> dataout=0x01, count stays 16, 0x55 read last.
- At empty, r_en and w_en together with din=0x33 -> underflow pulses, count=1, a subsequent read yields 0x33.
- 40 interleaved write/read pairs forcing pointer wrap -> output sequence equals input sequence, empty=1 at the end.
- rst driven low mid-stream at count=7 -> count=0, empty=1 and dataout=0 immediately; the next write/read round-trips correctly.
- Each scenario SHALL run with FIFO_FWFT_EN both defined and undefined.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the parameterised synchronous FIFO.
// Imported by fifo_mem and param_sync_fifo.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Error-status pair, registered together so both pulses share timing.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Pointer and count width: one extra bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH FIFO storage: one synchronous write port, one asynchronous read port, no reset.
// The asynchronous read port lets the top present the head entry with zero latency.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with registered occupancy/threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise the read data is registered.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic                   r_en,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dataout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  localparam logic [PW-1:0] ONE_LVL  = PW'(1);
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL   = PW'(AE_THRESH);

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    count_reg;
  logic [PW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             almost_full_reg;
  logic             almost_empty_reg;
  fifo_err_t        err_reg;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] rd_data;

  // A read frees a slot in the same cycle, so a write at full still lands.
  assign rd_acc = r_en && !empty_reg;
  assign wr_acc = w_en && (!full_reg || rd_acc);

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + ONE_LVL;
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - ONE_LVL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      err_reg          <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + ONE_LVL;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + ONE_LVL;
      end
      count_reg <= count_next;
      // Flags derive from the next count so they line up with count every cycle.
      full_reg         <= (count_next == FULL_LVL);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_LVL);
      almost_empty_reg <= (count_next <= AE_LVL);
      err_reg.overflow  <= w_en && !wr_acc;
      err_reg.underflow <= r_en && !rd_acc;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (din),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_data)
  );

`ifdef FIFO_FWFT_EN
  // Head entry falls through; forced to zero while empty so reset shows 0.
  assign dataout = empty_reg ? '0 : rd_data;
`else
  logic [WIDTH-1:0] dataout_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout_reg <= '0;
    end else if (rd_acc) begin
      dataout_reg <= rd_data;
    end
  end

  assign dataout = dataout_reg;
`endif

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = err_reg.overflow;
  assign underflow    = err_reg.underflow;

endmodule
